// File: rtl/clock_div_meter.sv
// clock_div_meter: measures the period of an asynchronous clk_in in src_clk cycles,
// recovers the equivalent divider value and reports lock / timeout status.
// Optional macro CLK_METER_HIGH_TIME_EN adds high_time_out and duty_ok.
module clock_div_meter #(
  parameter int WIDTH      = 33,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 1000000
) (
  input  logic             src_clk,
  input  logic             reset,
  input  logic             clk_in,
  input  logic             enable,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] div_out,
  output logic             odd_period,
  output logic             meas_valid,
  output logic             locked,
`ifdef CLK_METER_HIGH_TIME_EN
  output logic             timeout,
  output logic [WIDTH-1:0] high_time_out,
  output logic             duty_ok
`else
  output logic             timeout
`endif
);

  localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TWO        = {{(WIDTH-2){1'b0}}, 2'b10};
  localparam logic [WIDTH-1:0] TIMEOUT_M1 = WIDTH'(TIMEOUT - 1);
  localparam logic [3:0]       MATCH_MAX  = 4'(LOCK_COUNT - 1);

  typedef enum logic {
    ARM     = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             s1_r;
  logic             s2_r;
  logic             s3_r;
  logic             edge_s;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_nxt_s;
  logic [WIDTH-1:0] period_s;
  logic [WIDTH-1:0] div_s;
  logic [3:0]       match_r;
  logic [3:0]       match_nxt_s;
  logic [3:0]       match_inc_s;
  logic [WIDTH-1:0] period_nxt_s;
  logic [WIDTH-1:0] div_nxt_s;
  logic             odd_nxt_s;
  logic             valid_nxt_s;
  logic             locked_nxt_s;
  logic             timeout_nxt_s;
  logic             load_s;

  assign edge_s = s2_r & ~s3_r;

  // Period counter step and the arithmetic derived from the captured count.
  always_comb begin
    if (edge_s) begin
      cnt_nxt_s = '0;
    end else if (cnt_r == CNT_MAX) begin
      cnt_nxt_s = cnt_r;
    end else begin
      cnt_nxt_s = cnt_r + ONE;
    end
    if (cnt_r == CNT_MAX) begin
      period_s = cnt_r;
    end else begin
      period_s = cnt_r + ONE;
    end
    if (period_s < TWO) begin
      div_s = '0;
    end else begin
      div_s = (period_s >> 1) - ONE;
    end
    if (match_r == MATCH_MAX) begin
      match_inc_s = match_r;
    end else begin
      match_inc_s = match_r + 4'd1;
    end
  end

  // Next-state and next-output logic; an edge outranks a coincident timeout.
  always_comb begin
    state_nxt_s   = state_r;
    match_nxt_s   = match_r;
    period_nxt_s  = period_out;
    div_nxt_s     = div_out;
    odd_nxt_s     = odd_period;
    valid_nxt_s   = 1'b0;
    locked_nxt_s  = locked;
    timeout_nxt_s = timeout;
    load_s        = 1'b0;
    if (!enable) begin
      state_nxt_s  = ARM;
      match_nxt_s  = 4'd0;
      locked_nxt_s = 1'b0;
    end else begin
      case (state_r)
        ARM: begin
          if (edge_s) begin
            state_nxt_s   = MEASURE;
            timeout_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ARM;
          end
        end
        MEASURE: begin
          if (edge_s) begin
            load_s       = 1'b1;
            period_nxt_s = period_s;
            div_nxt_s    = div_s;
            odd_nxt_s    = period_s[0];
            valid_nxt_s  = 1'b1;
            if (period_s == period_out) begin
              match_nxt_s  = match_inc_s;
              locked_nxt_s = (match_inc_s == MATCH_MAX);
            end else begin
              match_nxt_s  = 4'd0;
              locked_nxt_s = (MATCH_MAX == 4'd0);
            end
          end else if (cnt_r == TIMEOUT_M1) begin
            state_nxt_s   = ARM;
            timeout_nxt_s = 1'b1;
            locked_nxt_s  = 1'b0;
            match_nxt_s   = 4'd0;
          end else begin
            state_nxt_s = MEASURE;
          end
        end
        default: begin
          state_nxt_s = ARM;
        end
      endcase
    end
  end

  // Synchronizer chain, period counter and FSM state register.
  always_ff @(posedge src_clk) begin
    if (reset) begin
      s1_r    <= 1'b0;
      s2_r    <= 1'b0;
      s3_r    <= 1'b0;
      cnt_r   <= '0;
      state_r <= ARM;
    end else begin
      s1_r    <= clk_in;
      s2_r    <= s1_r;
      s3_r    <= s2_r;
      cnt_r   <= cnt_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  // Measurement, lock and timeout output registers.
  always_ff @(posedge src_clk) begin
    if (reset) begin
      period_out <= '0;
      div_out    <= '0;
      odd_period <= 1'b0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
      match_r    <= 4'd0;
    end else begin
      period_out <= period_nxt_s;
      div_out    <= div_nxt_s;
      odd_period <= odd_nxt_s;
      meas_valid <= valid_nxt_s;
      locked     <= locked_nxt_s;
      timeout    <= timeout_nxt_s;
      match_r    <= match_nxt_s;
    end
  end

`ifdef CLK_METER_HIGH_TIME_EN
  logic [WIDTH-1:0] hcnt_r;
  logic [WIDTH-1:0] hcnt_nxt_s;
  logic [WIDTH:0]   twice_s;
  logic [WIDTH:0]   per_ext_s;
  logic             duty_s;

  // The window opens on the edge cycle, which is itself a high cycle of s2.
  always_comb begin
    if (edge_s) begin
      hcnt_nxt_s = ONE;
    end else if (s2_r && (hcnt_r != CNT_MAX)) begin
      hcnt_nxt_s = hcnt_r + ONE;
    end else begin
      hcnt_nxt_s = hcnt_r;
    end
    twice_s   = {hcnt_r, 1'b0};
    per_ext_s = {1'b0, period_s};
    if (twice_s >= per_ext_s) begin
      duty_s = ((twice_s - per_ext_s) <= {{WIDTH{1'b0}}, 1'b1});
    end else begin
      duty_s = ((per_ext_s - twice_s) <= {{WIDTH{1'b0}}, 1'b1});
    end
  end

  // High-time counter and the duty outputs captured with each measurement.
  always_ff @(posedge src_clk) begin
    if (reset) begin
      hcnt_r        <= '0;
      high_time_out <= '0;
      duty_ok       <= 1'b0;
    end else begin
      hcnt_r <= hcnt_nxt_s;
      if (load_s) begin
        high_time_out <= hcnt_r;
        duty_ok       <= duty_s;
      end else begin
        high_time_out <= high_time_out;
        duty_ok       <= duty_ok;
      end
    end
  end
`endif

endmodule

// File: tb/tb_clock_div_meter.sv
// Randomized self-checking bench for clock_div_meter: a queue-based model predicts
// every measurement from the clk_in rise times the bench itself produces.
module tb_clock_div_meter;

  localparam int WIDTH      = 33;
  localparam int LOCK_COUNT = 4;
  localparam int TIMEOUT    = 100;

  logic             src_clk = 1'b0;
  logic             reset;
  logic             clk_in;
  logic             enable;
  logic [WIDTH-1:0] period_out;
  logic [WIDTH-1:0] div_out;
  logic             odd_period;
  logic             meas_valid;
  logic             locked;
  logic             timeout;
`ifdef CLK_METER_HIGH_TIME_EN
  logic [WIDTH-1:0] high_time_out;
  logic             duty_ok;
`endif

  clock_div_meter #(
    .WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .src_clk(src_clk), .reset(reset), .clk_in(clk_in), .enable(enable),
    .period_out(period_out), .div_out(div_out), .odd_period(odd_period),
    .meas_valid(meas_valid), .locked(locked),
`ifdef CLK_METER_HIGH_TIME_EN
    .timeout(timeout), .high_time_out(high_time_out), .duty_ok(duty_ok)
`else
    .timeout(timeout)
`endif
  );

  always #5 src_clk = ~src_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge src_clk) cyc <= cyc + 1;

  // Reference model: measurements follow from rise-to-rise distances.
  int     armed = 0;
  longint last_rise = 0;
  longint last_p = 0;
  int     streak = 0;
  int     last_hi = 0;
  bit     exp_lock = 1'b0;
  longint q_p[$];
  bit     q_l[$];
  int     q_h[$];

  task automatic model_rise(input int hi);
    longint p;
    if (enable) begin
      if (armed != 0) begin
        p = longint'(cyc) - last_rise;
        if (p == last_p) begin
          if (streak < LOCK_COUNT) streak++;
        end else begin
          streak = 1;
        end
        last_p   = p;
        exp_lock = (streak >= LOCK_COUNT);
        q_p.push_back(p);
        q_l.push_back(exp_lock);
        q_h.push_back(last_hi);
      end
      armed = 1;
    end
    last_rise = cyc;
    last_hi   = hi;
  endtask

  task automatic model_unlock();
    armed    = 0;
    streak   = 1;
    exp_lock = 1'b0;
  endtask

  // Entered and left on a falling edge of src_clk.
  task automatic drive_period(input int hi, input int lo);
    clk_in = 1'b1;
    model_rise(hi);
    repeat (hi) @(negedge src_clk);
    clk_in = 1'b0;
    repeat (lo) @(negedge src_clk);
  endtask

  task automatic run_periods(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) drive_period(hi, lo);
  endtask

  task automatic wait_drain();
    repeat (6) @(negedge src_clk);
    checks++;
    if (q_p.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d measurements still pending, want 0", q_p.size());
    end
  endtask

  // Monitor: every meas_valid pulse must match the next predicted measurement.
  bit prev_valid = 1'b0;
  initial begin
    longint           p;
    logic [WIDTH-1:0] ew;
    logic [WIDTH-1:0] ed;
    bit               el;
    int               eh;
    forever begin
      @(posedge src_clk);
      #1;
      if (meas_valid === 1'b1) begin
        checks++;
        if (prev_valid) begin
          errors++;
          $display("FAIL valid_gap: meas_valid high two cycles running at cycle %0d", cyc);
        end
        checks++;
        if (q_p.size() == 0) begin
          errors++;
          $display("FAIL unexpected_meas: meas_valid at cycle %0d with period_out %0d, want none", cyc, period_out);
        end else begin
          p  = q_p.pop_front();
          el = q_l.pop_front();
          eh = q_h.pop_front();
          ew = WIDTH'(p);
          ed = (p < 2) ? '0 : WIDTH'(p / 2 - 1);
          checks++;
          if (period_out !== ew) begin
            errors++;
            $display("FAIL period_out: got %0d want %0d", period_out, ew);
          end
          checks++;
          if (div_out !== ed) begin
            errors++;
            $display("FAIL div_out: got %0d want %0d (period %0d)", div_out, ed, p);
          end
          checks++;
          if (odd_period !== ew[0]) begin
            errors++;
            $display("FAIL odd_period: got %b want %b", odd_period, ew[0]);
          end
          checks++;
          if (locked !== el) begin
            errors++;
            $display("FAIL locked_at_meas: got %b want %b (period %0d)", locked, el, p);
          end
`ifdef CLK_METER_HIGH_TIME_EN
          checks++;
          if (high_time_out !== WIDTH'(eh)) begin
            errors++;
            $display("FAIL high_time_out: got %0d want %0d", high_time_out, eh);
          end
          checks++;
          if (duty_ok !== ((2 * eh - p <= 1) && (p - 2 * eh <= 1))) begin
            errors++;
            $display("FAIL duty_ok: got %b for high %0d period %0d", duty_ok, eh, p);
          end
`endif
        end
      end
      prev_valid = (meas_valid === 1'b1);
    end
  end

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b1;
    clk_in = 1'b0;
    repeat (3) @(negedge src_clk);
    checks++;
    if ({period_out, div_out, odd_period, meas_valid, locked, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_state: got period %0d div %0d odd %b valid %b lock %b tmo %b, want all 0",
               period_out, div_out, odd_period, meas_valid, locked, timeout);
    end
    reset = 1'b0;
    armed = 0; last_p = 0; streak = 0; exp_lock = 1'b0;
    repeat (2) @(negedge src_clk);
  endtask

  task automatic test_basic();
    run_periods(6, 5, 5);
    checks++;
    if (locked !== 1'b1 || period_out !== WIDTH'(10) || div_out !== WIDTH'(4) || odd_period !== 1'b0) begin
      errors++;
      $display("FAIL basic_10: got lock %b period %0d div %0d odd %b, want 1 10 4 0",
               locked, period_out, div_out, odd_period);
    end
  endtask

  task automatic test_odd_and_min();
    run_periods(4, 3, 4);
    checks++;
    if (period_out !== WIDTH'(7) || div_out !== WIDTH'(2) || odd_period !== 1'b1) begin
      errors++;
      $display("FAIL odd_7: got period %0d div %0d odd %b, want 7 2 1", period_out, div_out, odd_period);
    end
    run_periods(4, 1, 1);
    checks++;
    if (period_out !== WIDTH'(2) || div_out !== WIDTH'(0)) begin
      errors++;
      $display("FAIL min_2: got period %0d div %0d, want 2 0", period_out, div_out);
    end
    run_periods(3, 1, 2);
    wait_drain();
  endtask

  task automatic test_relock();
    run_periods(6, 5, 5);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL relock_first: locked got %b want 1", locked);
    end
    run_periods(2, 6, 6);
    checks++;
    if (locked !== 1'b0 || period_out !== WIDTH'(12)) begin
      errors++;
      $display("FAIL relock_break: got lock %b period %0d, want 0 12", locked, period_out);
    end
    run_periods(4, 6, 6);
    checks++;
    if (locked !== 1'b1 || div_out !== WIDTH'(5)) begin
      errors++;
      $display("FAIL relock_12: got lock %b div %0d, want 1 5", locked, div_out);
    end
  endtask

  task automatic test_timeout();
    int waited;
    run_periods(6, 5, 5);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL pre_timeout_lock: locked got %b want 1", locked);
    end
    while (longint'(cyc) < last_rise + TIMEOUT) @(negedge src_clk);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: timeout got %b want 0 at %0d cycles after last rise", timeout, cyc - last_rise);
    end
    for (int i = 0; i < 20 && timeout !== 1'b1; i++) @(negedge src_clk);
    waited = int'(longint'(cyc) - last_rise);
    checks++;
    if (timeout !== 1'b1 || waited > TIMEOUT + 6) begin
      errors++;
      $display("FAIL timeout_assert: timeout got %b after %0d cycles, want 1 within %0d", timeout, waited, TIMEOUT + 6);
    end
    checks++;
    if (locked !== 1'b0 || period_out !== WIDTH'(10) || div_out !== WIDTH'(4)) begin
      errors++;
      $display("FAIL timeout_hold: got lock %b period %0d div %0d, want 0 10 4", locked, period_out, div_out);
    end
    model_unlock();
    clk_in = 1'b1;
    model_rise(5);
    repeat (5) @(negedge src_clk);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: timeout got %b want 0 after restart edge", timeout);
    end
    clk_in = 1'b0;
    repeat (5) @(negedge src_clk);
    run_periods(3, 5, 5);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    run_periods(3, 5, 5);
    clk_in = 1'b1;
    model_rise(5);
    repeat (5) @(negedge src_clk);
    clk_in = 1'b0;
    repeat (2) @(negedge src_clk);
    reset = 1'b1;
    @(negedge src_clk);
    reset = 1'b0;
    checks++;
    if ({period_out, div_out, odd_period, meas_valid, locked, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got period %0d div %0d odd %b valid %b lock %b tmo %b, want all 0",
               period_out, div_out, odd_period, meas_valid, locked, timeout);
    end
    armed = 0; last_p = 0; streak = 0; exp_lock = 1'b0;
    repeat (3) @(negedge src_clk);
    run_periods(4, 5, 5);
    checks++;
    if (period_out !== WIDTH'(10) || locked !== exp_lock) begin
      errors++;
      $display("FAIL reset_restart: got period %0d lock %b, want 10 %b", period_out, locked, exp_lock);
    end
    wait_drain();
  endtask

  task automatic test_enable();
    logic [WIDTH-1:0] held;
    run_periods(5, 5, 5);
    held   = period_out;
    enable = 1'b0;
    model_unlock();
    repeat (2) @(negedge src_clk);
    checks++;
    if (locked !== 1'b0 || meas_valid !== 1'b0 || period_out !== held || period_out !== WIDTH'(last_p)) begin
      errors++;
      $display("FAIL enable_off: got lock %b valid %b period %0d, want 0 0 %0d", locked, meas_valid, period_out, last_p);
    end
    run_periods(3, 5, 5);
    checks++;
    if (locked !== 1'b0 || period_out !== held) begin
      errors++;
      $display("FAIL enable_hold: got lock %b period %0d, want 0 %0d", locked, period_out, held);
    end
    enable = 1'b1;
    run_periods(5, 5, 5);
    checks++;
    if (locked !== 1'b1 || locked !== exp_lock) begin
      errors++;
      $display("FAIL enable_relock: locked got %b want 1", locked);
    end
    wait_drain();
  endtask

  task automatic test_random();
    int hi;
    int lo;
    int n;
    for (int s = 0; s < 12; s++) begin
      hi = $urandom_range(1, 7);
      lo = $urandom_range(1, 7);
      n  = $urandom_range(1, 5);
      run_periods(n, hi, lo);
    end
    wait_drain();
  endtask

`ifdef CLK_METER_HIGH_TIME_EN
  task automatic test_duty();
    run_periods(3, 5, 5);
    checks++;
    if (high_time_out !== WIDTH'(5) || duty_ok !== 1'b1) begin
      errors++;
      $display("FAIL duty_50: got high %0d ok %b, want 5 1", high_time_out, duty_ok);
    end
    run_periods(3, 3, 7);
    checks++;
    if (high_time_out !== WIDTH'(3) || duty_ok !== 1'b0) begin
      errors++;
      $display("FAIL duty_30: got high %0d ok %b, want 3 0", high_time_out, duty_ok);
    end
    wait_drain();
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_odd_and_min();
    test_relock();
    test_timeout();
    test_reset_mid();
    test_enable();
    test_random();
`ifdef CLK_METER_HIGH_TIME_EN
    test_duty();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_div_meter.md
Name: clock_div_meter

Overview:
- Measures an external divided clock (such as a `clock_divider` output) against `src_clk` and reports its period.
- Recovers the divider setting that would reproduce the measured clock.
- Flags lock once several consecutive periods match, and flags timeout if the clock stops.
- Sits on the return path of clock-generation logic for self-check and auto-calibration.

Parameters:
- WIDTH, 33: width of the period counter and of `period_out` / `div_out`. Matches the `clk_div` bus.
- LOCK_COUNT, 4: number of consecutive identical periods needed to assert `locked`. Legal range 1..15.
- TIMEOUT, 1000000: `src_clk` cycles without a detected rising edge before `timeout` asserts. Must be < 2^WIDTH.

Ports:
- src_clk  input  1  measurement clock. All logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- clk_in  input  1  clock under measurement. Asynchronous to `src_clk`.
- enable  input  1  when 0, measurement is held in ARM and outputs hold their values.
- period_out  output  WIDTH  last measured period, in `src_clk` cycles.
- div_out  output  WIDTH  equivalent divider value: (period_out >> 1) - 1, floored at 0.
- odd_period  output  1  period_out[0] of the last measurement. An odd period is not exactly reproducible by a divider.
- meas_valid  output  1  one-cycle pulse when new `period_out` / `div_out` values are loaded.
- locked  output  1  level signal: LOCK_COUNT consecutive equal periods have been seen.
- timeout  output  1  level signal: no edge seen for TIMEOUT cycles.

Behaviour:
- Reset values: period_out=0, div_out=0, odd_period=0, meas_valid=0, locked=0, timeout=0. Synchronizer flops=0, counter=0, match count=0, state=ARM.
- Synchronizer: `clk_in` passes through two flops (s1, s2), then a third flop s3.
  - edge = s2 & ~s3.
  - Latency from a `clk_in` rise to edge: 3 `src_clk` cycles.
  - Minimum measurable period is 2 `src_clk` cycles; shorter periods are undefined.
- Counter `cnt` (WIDTH bits): set to 0 in any edge cycle, otherwise increments by 1, saturating at all-ones.
- State ARM:
  - Waiting for the first edge; no measurement is produced.
  - Edge with enable=1 -> go to MEASURE, cnt<=0, timeout<=0.
- State MEASURE, on an edge:
  - period = cnt + 1.
  - Load period_out, div_out and odd_period in the same cycle; meas_valid=1 in the next cycle (registered pulse).
  - div_out = 0 when period < 2.
  - Lock logic:
    - If period == period_out (previous value): match count += 1, saturating at LOCK_COUNT-1. Otherwise match count <= 0 and locked <= 0.
    - locked <= 1 when the match count reaches LOCK_COUNT-1.
    - LOCK_COUNT=1 means locked asserts on the first completed measurement.
- Timeout: while in MEASURE with no edge and cnt == TIMEOUT-1, the next cycle sets timeout=1, locked=0, match count=0 and state=ARM. period_out and div_out keep their values.
- Simultaneous edge and timeout condition in the same cycle: the edge wins and a measurement is taken.
- `timeout` clears on the next edge seen in ARM.
- enable=0: state<=ARM, match count<=0, locked<=0, meas_valid=0; other outputs hold.
- Reset mid-measurement: everything returns to reset values in the next cycle. The first edge after reset only arms the block, so the first meas_valid comes on the second edge.
- meas_valid never asserts in two consecutive cycles, since period >= 2.

Optional Feature:
- Macro CLK_METER_HIGH_TIME_EN.
- When defined:
  - Adds output `high_time_out` (WIDTH bits, reset 0): the number of cycles s2 was high within the measured period.
  - Loaded together with period_out; a per-period counter clears on edge.
  - Adds output `duty_ok` (1 bit, reset 0), set when high_time_out*2 is within 1 of period. This is true for any valid `clock_divider` output.
- When undefined: neither port exists and no extra logic is generated.

Test Plan:
- Reset, then `clk_in` period 10 (5 high / 5 low) -> first meas_valid on the 2nd edge. period_out=10, div_out=4, odd_period=0. locked=1 after the 4th measurement of 10.
- `clk_in` period 7 -> period_out=7, div_out=2, odd_period=1. Period 2 -> div_out=0.
- Locked at period 10, then switch to 12 -> locked=0 on the first 12 measurement. Re-lock after 4 measurements of 12. div_out=5.
- Stop `clk_in` after lock, TIMEOUT=100 -> timeout=1 and locked=0 about 100 cycles after the last edge. period_out holds 10. Restart -> timeout clears on the first edge; the next edge gives meas_valid.
- Assert reset for 1 cycle mid-period, and separately drive enable=0 -> all outputs return to 0 (reset) or hold except locked=0 (enable). Measurement restarts with the arm edge.
- With CLK_METER_HIGH_TIME_EN defined, period 10 at 50% duty -> high_time_out=5, duty_ok=1. A 3/7 pattern gives duty_ok=0.
